insmem_loader: RTL and testbench

// Boot-time program loader sitting directly upstream of the instruction memory.

---
 rtl/insmem_loader_if.sv | 30 +++
 rtl/insmem_loader.sv | 114 +++++++++++
 tb/tb_insmem_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/insmem_loader_if.sv
`default_nettype none
// ============================================================================
// insmem_loader_if : byte-stream, control and memory-write bundle of the loader
// Revision: 1.0
// ============================================================================
interface insmem_loader_if #(
    parameter int PC_BITS = 6
);
    logic               start;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               we_insmem;
    logic [PC_BITS-1:0] pc;
    logic [15:0]        instruction_in;
    logic               busy;
    logic               done;
    logic               error;

    // master: the loader itself; slave: stream source, controller and memory
    modport master (
        input  start, rx_data, rx_valid,
        output rx_ready, we_insmem, pc, instruction_in, busy, done, error
    );
    modport slave (
        output start, rx_data, rx_valid,
        input  rx_ready, we_insmem, pc, instruction_in, busy, done, error
    );
endinterface
`default_nettype wire

// File: rtl/insmem_loader.sv
`default_nettype none
// ============================================================================
// insmem_loader : boot loader turning a counted big-endian byte stream into
//                 one-cycle instruction-memory write pulses
// Revision: 1.0
// ============================================================================
module insmem_loader #(
    parameter int PC_BITS = 6
) (
    input  wire logic        clk,
    input  wire logic        reset,
    insmem_loader_if.master  bus
);
    localparam int c_MAX_WORDS = 2 ** (PC_BITS - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LEN   = 3'd1;
    localparam logic [2:0] c_HI    = 3'd2;
    localparam logic [2:0] c_LO    = 3'd3;
    localparam logic [2:0] c_WRITE = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;
    localparam logic [2:0] c_ERROR = 3'd6;

    logic [2:0]         state_q, state_d;
    logic [7:0]         count_q, count_d;
    logic [PC_BITS-1:0] pc_q, pc_d;
    logic [15:0]        instr_q, instr_d;
    logic               we_q, we_d;

    logic w_rx_ready;
    logic w_accept;

    assign w_rx_ready = (state_q == c_LEN) || (state_q == c_HI) || (state_q == c_LO);
    assign w_accept   = w_rx_ready && bus.rx_valid;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        we_d    = 1'b0;
        case (state_q)
            c_IDLE, c_DONE, c_ERROR: begin
                if (bus.start) begin
                    state_d = c_LEN;
                    pc_d    = '0;
                end
            end
            c_LEN: begin
                if (w_accept) begin
                    if (bus.rx_data == 8'd0) begin
                        state_d = c_DONE;
                    end else if (32'(bus.rx_data) > c_MAX_WORDS) begin
                        state_d = c_ERROR;
                    end else begin
                        count_d = bus.rx_data;
                        state_d = c_HI;
                    end
                end
            end
            c_HI: begin
                if (w_accept) begin
                    instr_d[15:8] = bus.rx_data;
                    state_d       = c_LO;
                end
            end
            c_LO: begin
                if (w_accept) begin
                    instr_d[7:0] = bus.rx_data;
                    we_d         = 1'b1;
                    state_d      = c_WRITE;
                end
            end
            c_WRITE: begin
                // pc/instruction stay frozen through the pulse; advance afterwards
                count_d = count_q - 8'd1;
                if (count_q == 8'd1) begin
                    pc_d    = '0;
                    state_d = c_DONE;
                end else begin
                    pc_d    = pc_q + PC_BITS'(2);
                    state_d = c_HI;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_IDLE;
            count_q <= '0;
            pc_q    <= '0;
            instr_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            we_q    <= we_d;
        end
    end

    assign bus.rx_ready       = w_rx_ready;
    assign bus.we_insmem      = we_q;
    assign bus.pc             = pc_q;
    assign bus.instruction_in = instr_q;
    assign bus.busy           = (state_q == c_LEN) || (state_q == c_HI) ||
                                (state_q == c_LO)  || (state_q == c_WRITE);
    assign bus.done           = (state_q == c_DONE);
    assign bus.error          = (state_q == c_ERROR);
endmodule
`default_nettype wire

// File: tb/tb_insmem_loader.sv
`default_nettype none
// ============================================================================
// tb_insmem_loader : directed self-checking bench for insmem_loader
// Revision: 1.0
// ============================================================================
module tb_insmem_loader;
    localparam int PC_BITS = 6;

    typedef struct packed {
        logic [PC_BITS-1:0] pc;
        logic [15:0]        data;
    } wr_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    wr_t  wr_q[$];

    insmem_loader_if #(.PC_BITS(PC_BITS)) bus ();

    insmem_loader #(.PC_BITS(PC_BITS)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // we_insmem lasts exactly one cycle, so one falling-edge sample per write
    always @(negedge clk) begin
        if (bus.we_insmem === 1'b1) wr_q.push_back('{pc: bus.pc, data: bus.instruction_in});
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // called at a falling edge; returns at the falling edge right after the accept
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("rx_ready_timeout", 32'(n), 32'd0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'hxx;
        for (int i = 0; i < gap; i++) @(negedge clk);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (bus.done !== 1'b1 && bus.error !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("end_timeout", 32'(n), 32'd0);
    endtask

    task automatic check_wr(input string tag, input int idx, input int pc, input logic [15:0] data);
        if (idx < wr_q.size()) begin
            check_eq({tag, "_pc"}, 32'(wr_q[idx].pc), 32'(pc));
            check_eq({tag, "_data"}, 32'(wr_q[idx].data), 32'(data));
        end else begin
            check_eq({tag, "_missing"}, 32'(wr_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
        check_eq({tag, "_we"}, 32'(bus.we_insmem), 32'd0);
        check_eq({tag, "_pc"}, 32'(bus.pc), 32'd0);
        check_eq({tag, "_instr"}, 32'(bus.instruction_in), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_error"}, 32'(bus.error), 32'd0);
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // two words, back to back
        pulse_start();
        check_eq("t1_busy", 32'(bus.busy), 32'd1);
        check_eq("t1_rx_ready_len", 32'(bus.rx_ready), 32'd1);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        check_eq("t1_we_pulse", 32'(bus.we_insmem), 32'd1);
        check_eq("t1_rx_ready_write", 32'(bus.rx_ready), 32'd0);
        check_eq("t1_pulse_pc", 32'(bus.pc), 32'd0);
        check_eq("t1_pulse_instr", 32'(bus.instruction_in), 32'h1234);
        @(negedge clk);
        check_eq("t1_we_drop", 32'(bus.we_insmem), 32'd0);
        check_eq("t1_pc_adv", 32'(bus.pc), 32'd2);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        wait_end();
        check_eq("t1_done", 32'(bus.done), 32'd1);
        check_eq("t1_pc_final", 32'(bus.pc), 32'd0);
        check_eq("t1_nwr", 32'(wr_q.size()), 32'd2);
        check_wr("t1_w0", 0, 0, 16'h1234);
        check_wr("t1_w1", 1, 2, 16'hABCD);
        wr_q.delete();

        // empty program
        pulse_start();
        check_eq("t2_done_cleared", 32'(bus.done), 32'd0);
        send_byte(8'h00, 0);
        check_eq("t2_done", 32'(bus.done), 32'd1);
        check_eq("t2_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("t2_nwr", 32'(wr_q.size()), 32'd0);

        // header one beyond MAX_WORDS
        pulse_start();
        send_byte(8'h21, 0);
        check_eq("t3_error", 32'(bus.error), 32'd1);
        check_eq("t3_rx_ready", 32'(bus.rx_ready), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("t3_nwr", 32'(wr_q.size()), 32'd0);
        pulse_start();
        check_eq("t3_error_cleared", 32'(bus.error), 32'd0);
        check_eq("t3_busy", 32'(bus.busy), 32'd1);
        send_byte(8'h00, 0);

        // same as first load, rx_valid dropped every other cycle
        pulse_start();
        send_byte(8'h02, 1);
        send_byte(8'h12, 1);
        send_byte(8'h34, 1);
        send_byte(8'hAB, 1);
        send_byte(8'hCD, 1);
        wait_end();
        check_eq("t4_done", 32'(bus.done), 32'd1);
        check_eq("t4_nwr", 32'(wr_q.size()), 32'd2);
        check_wr("t4_w0", 0, 0, 16'h1234);
        check_wr("t4_w1", 1, 2, 16'hABCD);
        wr_q.delete();

        // reset in the middle of a load
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("t5_rst");
        reset = 1'b0;
        check_eq("t5_nwr_before", 32'(wr_q.size()), 32'd1);
        wr_q.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        wait_end();
        check_eq("t5_done", 32'(bus.done), 32'd1);
        check_eq("t5_nwr", 32'(wr_q.size()), 32'd1);
        check_wr("t5_w0", 0, 0, 16'hBEEF);
        wr_q.delete();

        // full memory; start while busy must be ignored
        pulse_start();
        send_byte(8'h20, 0);
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin
                pulse_start();
                check_eq("t6_busy_after_start", 32'(bus.busy), 32'd1);
                check_eq("t6_pc_kept", 32'(bus.pc), 32'd20);
            end
            send_byte(8'(i + 8'h40), 0);
            send_byte(8'(8'hC0 - i), 0);
            if (i == 31) check_eq("t6_last_pc", 32'(bus.pc), 32'd62);
        end
        wait_end();
        check_eq("t6_done", 32'(bus.done), 32'd1);
        check_eq("t6_pc_final", 32'(bus.pc), 32'd0);
        check_eq("t6_nwr", 32'(wr_q.size()), 32'd32);
        for (int i = 0; i < 32; i++) begin
            check_wr($sformatf("t6_w%0d", i), i, 2 * i, {8'(i + 8'h40), 8'(8'hC0 - i)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
